// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, the queued-write entry type and the pixel-to-word address map.
package fb_pkg;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int FRAME_WORDS = 307200;
  localparam int FB_ADDR_W   = 20;
  localparam int FB_DATA_W   = 16;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] data;
  } fb_entry_t;

  // y*640 is formed as (y<<9)+(y<<7) so no multiplier is needed.
  function automatic logic [FB_ADDR_W-1:0] pixel_addr(input logic       back_frame,
                                                      input logic [9:0] x,
                                                      input logic [9:0] y);
    logic [FB_ADDR_W-1:0] base;
    logic [FB_ADDR_W-1:0] yy;
    base = back_frame ? FB_ADDR_W'(FRAME_WORDS) : '0;
    yy   = FB_ADDR_W'(y);
    return base + (yy << 9) + (yy << 7) + FB_ADDR_W'(x);
  endfunction

endpackage

// File: rtl/fb_sync_fifo.sv
// Single-clock FIFO with registered storage and a show-ahead head; clear empties it at the next edge.
module fb_sync_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             push,
  input  T                 push_data,
  input  logic             pop,
  output T                 head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH on their own.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
  end

  // NOTE: storage is deliberately not reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  assign head  = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fb_write_queue.sv
// Copy-engine write stage: maps pixels to back-buffer word addresses, queues them and drains on grant.
module fb_write_queue
  import fb_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [9:0]        program_x,
  input  logic [9:0]        program_y,
  input  logic [DATA_W-1:0] program_data,
  input  logic              program_write,
  output logic              program_ready,
  input  logic              current_frame,
  input  logic              flush,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_data,
  output logic              sram_we,
  input  logic              sram_grant,
  output logic              idle,
  output logic [15:0]       drop_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;

  logic        stage1_valid_q, stage1_valid_d;
  fb_entry_t   stage1_q, stage1_d;
  logic [15:0] drop_count_q, drop_count_d;

  fb_entry_t        fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty, fifo_full;
  logic [OCC_W-1:0] occupancy;
  logic             in_range, offered, accept, drop;

  // Ready leaves room for whatever sits in stage1, so its unconditional push can never overflow.
  assign occupancy     = OCC_W'(fifo_count) + OCC_W'(stage1_valid_q);
  assign program_ready = !fifo_full && (occupancy <= OCC_W'(DEPTH - 1));

  assign in_range = (program_x < 10'(SCREEN_W)) && (program_y < 10'(SCREEN_H));
  assign offered  = program_write && !flush;
  assign accept   = offered && program_ready && in_range;
  assign drop     = offered && !accept;

  always_comb begin
    stage1_valid_d = accept;
    stage1_d       = stage1_q;
    drop_count_d   = drop_count_q;
    if (accept) begin
      stage1_d.addr = pixel_addr(~current_frame, program_x, program_y);
      stage1_d.data = program_data;
    end
    if (drop && drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      stage1_valid_q <= 1'b0;
      drop_count_q   <= '0;
    end else begin
      stage1_valid_q <= stage1_valid_d;
      drop_count_q   <= drop_count_d;
    end
    stage1_q <= stage1_d;
  end

  fb_sync_fifo #(
    .T     (fb_entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .clear     (RESET || flush),
    .push      (stage1_valid_q),
    .push_data (stage1_q),
    .pop       (sram_we && sram_grant),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign sram_we    = !fifo_empty;
  assign sram_addr  = fifo_head.addr;
  assign sram_data  = fifo_head.data;
  assign idle       = !stage1_valid_q && fifo_empty;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_fb_write_queue.sv
// Directed bench for fb_write_queue: address map, ordering, backpressure, drops, retarget, flush, reset.
module tb_fb_write_queue;

  logic        CLK;
  logic        RESET;
  logic [9:0]  program_x;
  logic [9:0]  program_y;
  logic [15:0] program_data;
  logic        program_write;
  logic        program_ready;
  logic        current_frame;
  logic        flush;
  logic [19:0] sram_addr;
  logic [15:0] sram_data;
  logic        sram_we;
  logic        sram_grant;
  logic        idle;
  logic [15:0] drop_count;

  int errors = 0;
  int checks = 0;

  fb_write_queue #(.DEPTH(8), .ADDR_W(20), .DATA_W(16)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .program_x     (program_x),
    .program_y     (program_y),
    .program_data  (program_data),
    .program_write (program_write),
    .program_ready (program_ready),
    .current_frame (current_frame),
    .flush         (flush),
    .sram_addr     (sram_addr),
    .sram_data     (sram_data),
    .sram_we       (sram_we),
    .sram_grant    (sram_grant),
    .idle          (idle),
    .drop_count    (drop_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [9:0] x, input logic [9:0] y, input logic [15:0] d);
    program_x     = x;
    program_y     = y;
    program_data  = d;
    program_write = 1'b1;
    step();
    program_write = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
  endtask

  // Expects sram_grant=1: waits (bounded) for the head, checks it, then lets it pop.
  task automatic pop_check(input string tag, input logic [19:0] ea, input logic [15:0] ed);
    int n = 0;
    while (sram_we !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({tag, " we"}, sram_we, 1);
    check({tag, " addr"}, sram_addr, ea);
    check({tag, " data"}, sram_data, ed);
    step();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " ready"}, program_ready, 1);
    check({tag, " we"}, sram_we, 0);
    check({tag, " idle"}, idle, 1);
  endtask

  initial begin
    RESET         = 1'b1;
    program_x     = '0;
    program_y     = '0;
    program_data  = '0;
    program_write = 1'b0;
    current_frame = 1'b0;
    flush         = 1'b0;
    sram_grant    = 1'b0;
    step();
    step();
    RESET = 1'b0;
    check_reset_state("reset");
    check("reset drops", drop_count, 0);

    // 1: single pixel, frame 0 displayed so it lands in frame 1.
    sram_grant = 1'b1;
    wr(10'd5, 10'd2, 16'hABCD);
    check("t1 we after accept", sram_we, 0);
    check("t1 busy in stage1", idle, 0);
    step();
    check("t1 we after push", sram_we, 1);
    check("t1 addr", sram_addr, 20'h4B505);
    check("t1 data", sram_data, 16'hABCD);
    step();
    check("t1 we after pop", sram_we, 0);
    check("t1 idle", idle, 1);

    // 2: corner pixels in both frames, in order.
    sram_grant    = 1'b0;
    current_frame = 1'b1;
    wr(10'd639, 10'd479, 16'h1111);
    wr(10'd0,   10'd0,   16'h2222);
    sram_grant = 1'b1;
    pop_check("t2 f0 first", 20'h4AFFF, 16'h1111);
    pop_check("t2 f0 second", 20'h00000, 16'h2222);
    sram_grant    = 1'b0;
    current_frame = 1'b0;
    wr(10'd639, 10'd479, 16'h3333);
    wr(10'd0,   10'd0,   16'h4444);
    sram_grant = 1'b1;
    pop_check("t2 f1 first", 20'h95FFF, 16'h3333);
    pop_check("t2 f1 second", 20'h4B000, 16'h4444);
    check("t2 idle", idle, 1);

    // 3: backpressure with no grants: eight accepted, the rest dropped one per cycle.
    sram_grant    = 1'b0;
    current_frame = 1'b1;
    for (int i = 0; i < 12; i++) begin
      program_x     = 10'(i);
      program_y     = 10'd1;
      program_data  = 16'h3000 + 16'(i);
      program_write = 1'b1;
      check($sformatf("t3 ready %0d", i), program_ready, (i < 8));
      step();
      check($sformatf("t3 drops %0d", i), drop_count, (i < 8) ? 0 : i - 7);
    end
    program_write = 1'b0;
    step();
    check("t3 ready stays low", program_ready, 0);
    check("t3 head valid", sram_we, 1);
    sram_grant = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pop_check($sformatf("t3 drain %0d", i), 20'd640 + 20'(i), 16'h3000 + 16'(i));
    end
    check("t3 idle after drain", idle, 1);
    check("t3 ready after drain", program_ready, 1);

    // 4: out-of-range coordinates are dropped.
    do_reset();
    check("t4 drops cleared", drop_count, 0);
    wr(10'd640, 10'd0,   16'h5555);
    check("t4 idle after x=640", idle, 1);
    wr(10'd0,   10'd480, 16'h6666);
    step();
    check("t4 no we", sram_we, 0);
    check("t4 idle", idle, 1);
    check("t4 drops", drop_count, 2);

    // 5: frame toggle after queueing does not retarget queued entries.
    sram_grant    = 1'b0;
    current_frame = 1'b0;
    wr(10'd1,   10'd0,   16'h0A01);
    wr(10'd2,   10'd3,   16'h0A02);
    wr(10'd639, 10'd479, 16'h0A03);
    current_frame = 1'b1;
    sram_grant    = 1'b1;
    pop_check("t5 first", 20'h4B001, 16'h0A01);
    pop_check("t5 second", 20'h4B782, 16'h0A02);
    pop_check("t5 third", 20'h95FFF, 16'h0A03);

    // 6: flush beats a same-cycle write and grant; then reset mid-drain.
    sram_grant    = 1'b0;
    current_frame = 1'b0;
    for (int i = 0; i < 5; i++) wr(10'(i), 10'd9, 16'h0B00 + 16'(i));
    step();
    check("t6 queued", sram_we, 1);
    flush         = 1'b1;
    sram_grant    = 1'b1;
    program_x     = 10'd7;
    program_y     = 10'd7;
    program_write = 1'b1;
    step();
    flush         = 1'b0;
    sram_grant    = 1'b0;
    program_write = 1'b0;
    check_reset_state("t6 flush");
    check("t6 drops kept", drop_count, 2);
    step();
    check("t6 flushed write gone", sram_we, 0);
    check("t6 still idle", idle, 1);

    sram_grant = 1'b1;
    wr(10'd10, 10'd0, 16'h0C01);
    wr(10'd11, 10'd0, 16'h0C02);
    wr(10'd12, 10'd0, 16'h0C03);
    check("t6 mid-drain we", sram_we, 1);
    check("t6 mid-drain head", sram_addr, 20'h4B00B);
    do_reset();
    check_reset_state("t6 reset");
    check("t6 reset drops", drop_count, 0);
    step();
    check("t6 reset stays empty", sram_we, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
